// File: rtl/iram_bitmem_ctrl.sv
// Internal data RAM controller: byte/bit access over req/ack, bit writes as read-modify-write,
// accesses above the IRAM boundary forwarded to a wait-stated SFR bus, self-clearing after reset.
module iram_bitmem_ctrl #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned IRAM_DEPTH = 128,
    parameter int unsigned BIT_BASE   = 32,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr,
    input  logic              is_bit_addr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_bit_data,
    output logic              ready,
    output logic              ack,
    output logic [DATA_W-1:0] out_data,
    output logic              out_bit_data,
    output logic              sfr_req,
    output logic              sfr_wr,
    output logic [ADDR_W-1:0] sfr_addr,
    output logic [DATA_W-1:0] sfr_wdata,
    input  logic [DATA_W-1:0] sfr_rdata,
    input  logic              sfr_ack
);

    localparam int unsigned BS     = $clog2(DATA_W);
    localparam int unsigned MEM_AW = (IRAM_DEPTH > 1) ? $clog2(IRAM_DEPTH) : 1;

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_RMW_WR, S_SFR_RD, S_SFR_WR, S_DONE} state_t;

    state_t state_q, state_d;
    logic [MEM_AW-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d, bit_q, bit_d, bdata_q, bdata_d;
    logic [DATA_W-1:0] buf_q, buf_d;

    logic              ready_d, ack_d, out_bit_d, sfr_req_d, sfr_wr_d;
    logic [DATA_W-1:0] out_data_d, sfr_wdata_d;
    logic [ADDR_W-1:0] sfr_addr_d;

    logic [DATA_W-1:0] mem [IRAM_DEPTH];
    logic              mem_we;
    logic [MEM_AW-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [ADDR_W-1:0] cur_addr, bit_sfr_addr;
    logic [MEM_AW-1:0] bit_word, byte_word;
    logic [BS-1:0]     bit_idx;
    logic              bit_in_iram, byte_in_iram;
    logic [DATA_W-1:0] rmw_val, sfr_mod_val;

    // Decode from live inputs while idle, from the captured request afterwards
    assign cur_addr     = (state_q == S_IDLE) ? addr : addr_q;
    assign bit_idx      = cur_addr[BS-1:0];
    assign bit_in_iram  = ~cur_addr[ADDR_W-1];
    assign bit_word     = MEM_AW'(BIT_BASE + 32'(cur_addr[ADDR_W-2:BS]));
    assign bit_sfr_addr = {cur_addr[ADDR_W-1:BS], {BS{1'b0}}};
    assign byte_word    = MEM_AW'(cur_addr);
    assign byte_in_iram = ({1'b0, cur_addr} < (ADDR_W+1)'(IRAM_DEPTH));

    always_comb begin
        rmw_val          = buf_q;
        rmw_val[bit_idx] = bdata_q;
    end

    always_comb begin
        sfr_mod_val          = sfr_rdata;
        sfr_mod_val[bit_idx] = bdata_q;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wr_d        = wr_q;
        bit_d       = bit_q;
        bdata_d     = bdata_q;
        buf_d       = buf_q;
        ready_d     = 1'b0;
        ack_d       = 1'b0;
        out_data_d  = out_data;
        out_bit_d   = out_bit_data;
        sfr_req_d   = sfr_req;
        sfr_wr_d    = sfr_wr;
        sfr_addr_d  = sfr_addr;
        sfr_wdata_d = sfr_wdata;
        mem_we      = 1'b0;
        mem_waddr   = '0;
        mem_wdata   = '0;
        case (state_q)
            S_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = RST_VAL;
                if (cnt_q == MEM_AW'(IRAM_DEPTH - 1)) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + MEM_AW'(1);
                end
            end
            S_IDLE: begin
                ready_d = 1'b1;
                if (req) begin
                    ready_d = 1'b0;
                    addr_d  = addr;
                    wr_d    = wr;
                    bit_d   = is_bit_addr;
                    bdata_d = in_bit_data;
                    if (is_bit_addr) begin
                        if (bit_in_iram) begin
                            if (wr) begin
                                buf_d   = mem[bit_word];
                                state_d = S_RMW_WR;
                            end else begin
                                out_bit_d = mem[bit_word][bit_idx];
                                state_d   = S_DONE;
                            end
                        end else begin
                            sfr_req_d  = 1'b1;
                            sfr_wr_d   = 1'b0;
                            sfr_addr_d = bit_sfr_addr;
                            state_d    = S_SFR_RD;
                        end
                    end else if (byte_in_iram) begin
                        if (wr) begin
                            mem_we    = 1'b1;
                            mem_waddr = byte_word;
                            mem_wdata = in_data;
                        end else begin
                            out_data_d = mem[byte_word];
                        end
                        state_d = S_DONE;
                    end else begin
                        sfr_req_d  = 1'b1;
                        sfr_wr_d   = wr;
                        sfr_addr_d = addr;
                        if (wr) begin
                            sfr_wdata_d = in_data;
                            state_d     = S_SFR_WR;
                        end else begin
                            state_d = S_SFR_RD;
                        end
                    end
                end
            end
            S_RMW_WR: begin
                mem_we    = 1'b1;
                mem_waddr = bit_word;
                mem_wdata = rmw_val;
                state_d   = S_DONE;
            end
            S_SFR_RD: begin
                // A bit write keeps sfr_req up and turns the read into the write-back
                if (sfr_ack) begin
                    if (bit_q && wr_q) begin
                        sfr_wdata_d = sfr_mod_val;
                        sfr_wr_d    = 1'b1;
                        state_d     = S_SFR_WR;
                    end else begin
                        if (bit_q) begin
                            out_bit_d = sfr_rdata[bit_idx];
                        end else begin
                            out_data_d = sfr_rdata;
                        end
                        sfr_req_d = 1'b0;
                        state_d   = S_DONE;
                    end
                end
            end
            S_SFR_WR: begin
                if (sfr_ack) begin
                    sfr_req_d = 1'b0;
                    sfr_wr_d  = 1'b0;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                ack_d   = 1'b1;
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_INIT;
            cnt_q        <= '0;
            addr_q       <= '0;
            wr_q         <= 1'b0;
            bit_q        <= 1'b0;
            bdata_q      <= 1'b0;
            buf_q        <= '0;
            ready        <= 1'b0;
            ack          <= 1'b0;
            out_data     <= '0;
            out_bit_data <= 1'b0;
            sfr_req      <= 1'b0;
            sfr_wr       <= 1'b0;
            sfr_addr     <= '0;
            sfr_wdata    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wr_q         <= wr_d;
            bit_q        <= bit_d;
            bdata_q      <= bdata_d;
            buf_q        <= buf_d;
            ready        <= ready_d;
            ack          <= ack_d;
            out_data     <= out_data_d;
            out_bit_data <= out_bit_d;
            sfr_req      <= sfr_req_d;
            sfr_wr       <= sfr_wr_d;
            sfr_addr     <= sfr_addr_d;
            sfr_wdata    <= sfr_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_iram_bitmem_ctrl.sv
// Bench for iram_bitmem_ctrl: directed vector table, randomized accesses against a reference
// model, SFR bus responder with programmable wait states, and reset/abort sequences.
module tb_iram_bitmem_ctrl;

    logic       clk = 1'b0, rst = 1'b1, req = 1'b0, wr = 1'b0, is_bit_addr = 1'b0, in_bit_data = 1'b0;
    logic [7:0] addr = 8'h00, in_data = 8'h00;
    logic       ready, ack, out_bit_data, sfr_req, sfr_wr;
    logic [7:0] out_data, sfr_addr, sfr_wdata;
    logic [7:0] sfr_rdata = 8'h00;
    logic       sfr_ack = 1'b0;

    int checks = 0, failures = 0;

    typedef struct { logic w; logic [7:0] a; logic [7:0] d; } txn_t;
    txn_t obs_q[$], exp_q[$];

    typedef struct {
        logic w; logic b; logic [7:0] a; logic [7:0] d; logic bd; int wt; bit busy;
        logic [7:0] xd; logic xb; int xlat;
    } vec_t;
    vec_t vecs[19];

    logic [7:0] sfr_mem [256];
    logic [7:0] ref_sfr [256];
    logic [7:0] ref_mem [128];
    int         sfr_wait = 0, sfr_cnt = 0;
    logic [7:0] exp_data = 8'h00;
    logic       exp_bit = 1'b0;
    int         exp_lat = 2;
    bit         exp_is_sfr = 1'b0;

    always #5 clk = ~clk;

    iram_bitmem_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .is_bit_addr(is_bit_addr), .addr(addr),
        .in_data(in_data), .in_bit_data(in_bit_data), .ready(ready), .ack(ack),
        .out_data(out_data), .out_bit_data(out_bit_data), .sfr_req(sfr_req), .sfr_wr(sfr_wr),
        .sfr_addr(sfr_addr), .sfr_wdata(sfr_wdata), .sfr_rdata(sfr_rdata), .sfr_ack(sfr_ack)
    );

    // SFR responder: acks after sfr_wait+1 cycles of sfr_req, one-cycle ack pulse
    always @(posedge clk) begin
        if (sfr_req && !sfr_ack) begin
            if (sfr_cnt >= sfr_wait) begin
                sfr_ack   <= 1'b1;
                sfr_cnt   <= 0;
                sfr_rdata <= sfr_mem[sfr_addr];
                if (sfr_wr) sfr_mem[sfr_addr] <= sfr_wdata;
                obs_q.push_back('{sfr_wr, sfr_addr, sfr_wdata});
            end else begin
                sfr_cnt <= sfr_cnt + 1;
            end
        end else begin
            sfr_ack <= 1'b0;
            sfr_cnt <= 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, want);
        end
    endtask

    // Reference model: expected results, latency and SFR traffic from the address map rules
    task automatic model(input logic w, input logic b, input logic [7:0] a, input logic [7:0] d,
                         input logic bd);
        int idx, word;
        bit iram;
        logic [7:0] v;
        exp_q.delete();
        idx  = int'(a) % 8;
        iram = (a < 8'd128);
        word = int'(a);
        if (b) word = iram ? 32 + int'(a) / 8 : int'(a) - idx;
        exp_is_sfr = !iram;
        exp_lat    = 2;
        if (iram) begin
            if (b && w) begin
                v = ref_mem[word]; v[idx] = bd; ref_mem[word] = v; exp_lat = 3;
            end else if (b) begin
                exp_bit = ref_mem[word][idx];
            end else if (w) begin
                ref_mem[word] = d;
            end else begin
                exp_data = ref_mem[word];
            end
        end else if (b) begin
            exp_q.push_back('{1'b0, 8'(word), 8'h00});
            if (w) begin
                v = ref_sfr[word]; v[idx] = bd; ref_sfr[word] = v;
                exp_q.push_back('{1'b1, 8'(word), v});
            end else begin
                exp_bit = ref_sfr[word][idx];
            end
        end else if (w) begin
            exp_q.push_back('{1'b1, a, d});
            ref_sfr[a] = d;
        end else begin
            exp_q.push_back('{1'b0, a, 8'h00});
            exp_data = ref_sfr[a];
        end
    endtask

    // Issue one request at a negedge and follow it to its ack; k counts edges from acceptance
    task automatic access(input logic w, input logic b, input logic [7:0] a, input logic [7:0] d,
                          input logic bd, input int wt, input bit busy, output int k_ack);
        int k, samp;
        logic prev_req, prev_ack;
        logic [7:0] prev_addr;
        model(w, b, a, d, bd);
        sfr_wait = wt;
        obs_q.delete();
        check("ready_at_req", 32'(ready), 1);
        req = 1'b1; wr = w; is_bit_addr = b; addr = a; in_data = d; in_bit_data = bd;
        @(negedge clk);
        k = 1; samp = -100; k_ack = -1;
        req = 1'b0;
        check("busy_after_accept", {30'd0, ready, ack}, 0);
        if (busy) begin
            req = 1'b1; wr = 1'b1; is_bit_addr = 1'b0; addr = 8'h10; in_data = 8'hEE;
        end
        prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 8'h00;
        while (!ack && k < 200) begin
            if (busy && k == 3) req = 1'b0;
            if (sfr_req && prev_req && !prev_ack) check("sfr_addr_stable", 32'(sfr_addr), 32'(prev_addr));
            if (sfr_ack && sfr_req) samp = k;
            prev_req = sfr_req; prev_ack = sfr_ack; prev_addr = sfr_addr;
            @(negedge clk);
            k++;
        end
        req = 1'b0;
        if (!ack) begin
            checks++; failures++;
            $display("FAIL ack_timeout: actual=no ack after %0d cycles required=ack", k);
        end else begin
            k_ack = k;
            if (exp_is_sfr) check("sfr_ack_to_ack", 32'(k), 32'(samp + 2));
            else            check("iram_latency", 32'(k), 32'(exp_lat));
            check("out_data", 32'(out_data), 32'(exp_data));
            check("out_bit_data", 32'(out_bit_data), 32'(exp_bit));
            check("sfr_txn_count", 32'(obs_q.size()), 32'(exp_q.size()));
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                check("sfr_txn_wr", 32'(obs_q[i].w), 32'(exp_q[i].w));
                check("sfr_txn_addr", 32'(obs_q[i].a), 32'(exp_q[i].a));
                if (exp_q[i].w) check("sfr_txn_wdata", 32'(obs_q[i].d), 32'(exp_q[i].d));
            end
        end
    endtask

    task automatic wait_init(input string tag);
        int cnt;
        bit seen_ack;
        cnt = 0; seen_ack = 1'b0;
        while (!ready && cnt < 300) begin
            if (ack) seen_ack = 1'b1;
            cnt++;
            @(negedge clk);
        end
        req = 1'b0;
        check({tag, "_ready_low_cycles"}, 32'(cnt), 128);
        check({tag, "_no_ack"}, 32'(seen_ack), 0);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 256; i++) sfr_mem[i] = 8'(i * 7 + 3);
        sfr_mem[8'hE0] = 8'h50;
        sfr_mem[8'h90] = 8'h3C;
        for (int i = 0; i < 256; i++) ref_sfr[i] = sfr_mem[i];
        for (int i = 0; i < 128; i++) ref_mem[i] = 8'h00;

        vecs[0]  = '{1'b0, 1'b0, 8'h45, 8'h00, 1'b0, 0, 1'b0, 8'h00, 1'b0, 2};
        vecs[1]  = '{1'b1, 1'b0, 8'h2F, 8'hA5, 1'b0, 0, 1'b0, 8'h00, 1'b0, 2};
        vecs[2]  = '{1'b1, 1'b1, 8'h7A, 8'h00, 1'b0, 0, 1'b0, 8'h00, 1'b0, 3};
        vecs[3]  = '{1'b0, 1'b0, 8'h2F, 8'h00, 1'b0, 0, 1'b0, 8'hA1, 1'b0, 2};
        vecs[4]  = '{1'b1, 1'b0, 8'h20, 8'h01, 1'b0, 0, 1'b0, 8'hA1, 1'b0, 2};
        vecs[5]  = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 0, 1'b0, 8'hA1, 1'b1, 2};
        vecs[6]  = '{1'b0, 1'b1, 8'h07, 8'h00, 1'b0, 0, 1'b0, 8'hA1, 1'b0, 2};
        vecs[7]  = '{1'b1, 1'b1, 8'hE3, 8'h00, 1'b1, 3, 1'b0, 8'hA1, 1'b0, 12};
        vecs[8]  = '{1'b0, 1'b0, 8'h90, 8'h00, 1'b0, 5, 1'b1, 8'h3C, 1'b0, 9};
        vecs[9]  = '{1'b0, 1'b0, 8'h10, 8'h00, 1'b0, 0, 1'b0, 8'h00, 1'b0, 2};
        vecs[10] = '{1'b0, 1'b1, 8'hE3, 8'h00, 1'b0, 0, 1'b0, 8'h00, 1'b1, 4};
        vecs[11] = '{1'b0, 1'b0, 8'hE0, 8'h00, 1'b0, 1, 1'b0, 8'h58, 1'b1, 5};
        vecs[12] = '{1'b1, 1'b0, 8'hA0, 8'h77, 1'b0, 2, 1'b0, 8'h58, 1'b1, 6};
        vecs[13] = '{1'b1, 1'b0, 8'h7F, 8'h5A, 1'b0, 0, 1'b0, 8'h58, 1'b1, 2};
        vecs[14] = '{1'b0, 1'b0, 8'h7F, 8'h00, 1'b0, 0, 1'b0, 8'h5A, 1'b1, 2};
        vecs[15] = '{1'b0, 1'b0, 8'h80, 8'h00, 1'b0, 0, 1'b0, 8'h83, 1'b1, 4};
        vecs[16] = '{1'b1, 1'b1, 8'h79, 8'h00, 1'b1, 0, 1'b0, 8'h83, 1'b1, 3};
        vecs[17] = '{1'b0, 1'b0, 8'h2F, 8'h00, 1'b0, 0, 1'b0, 8'hA3, 1'b1, 2};
        vecs[18] = '{1'b0, 1'b0, 8'hA0, 8'h00, 1'b0, 0, 1'b0, 8'h77, 1'b1, 4};

        // Reset values, then INIT length with a stray request held throughout
        @(negedge clk);
        check("rst_ready", 32'(ready), 0);
        check("rst_ack", 32'(ack), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_bit", 32'(out_bit_data), 0);
        check("rst_sfr_req", 32'(sfr_req), 0);
        check("rst_sfr_wr", 32'(sfr_wr), 0);
        check("rst_sfr_addr", 32'(sfr_addr), 0);
        check("rst_sfr_wdata", 32'(sfr_wdata), 0);
        @(negedge clk);
        req = 1'b1; wr = 1'b1; addr = 8'h45; in_data = 8'hFF;
        rst = 1'b0;
        wait_init("init");

        for (int i = 0; i < 19; i++) begin
            access(vecs[i].w, vecs[i].b, vecs[i].a, vecs[i].d, vecs[i].bd, vecs[i].wt, vecs[i].busy, k);
            check($sformatf("vec%0d_latency", i), 32'(k), 32'(vecs[i].xlat));
            check($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].xd));
            check($sformatf("vec%0d_out_bit", i), 32'(out_bit_data), 32'(vecs[i].xb));
        end

        for (int i = 0; i < 150; i++) begin
            access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                   8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                   1'b0, k);
        end

        // Reset while an SFR read is stalled: request drops, no ack, array cleared again
        sfr_wait = 20;
        obs_q.delete();
        req = 1'b1; wr = 1'b0; is_bit_addr = 1'b0; addr = 8'h90;
        @(negedge clk);
        req = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_sfr_req_before", 32'(sfr_req), 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_sfr_req_after", 32'(sfr_req), 0);
        check("abort_ack", 32'(ack), 0);
        check("abort_ready", 32'(ready), 0);
        check("abort_out_data", 32'(out_data), 0);
        rst = 1'b0;
        wait_init("reinit");
        check("abort_no_sfr_txn", 32'(obs_q.size()), 0);
        for (int i = 0; i < 128; i++) ref_mem[i] = 8'h00;
        exp_data = 8'h00;
        exp_bit  = 1'b0;
        access(1'b0, 1'b0, 8'h2F, 8'h00, 1'b0, 0, 1'b0, k);
        check("post_reset_read_2f", 32'(out_data), 0);
        access(1'b0, 1'b0, 8'h20, 8'h00, 1'b0, 0, 1'b0, k);
        check("post_reset_read_20", 32'(out_data), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
